// File: rtl/painel_scan_ctrl.sv
// Column-scan sequencer for a 5x7 LED panel: fetches each column's row pattern from a
// synchronous ROM, lights it, blanks, and scrolls the message every SCROLL_FRAMES frames.
module painel_scan_ctrl #(
  parameter int unsigned COL_TICKS     = 1000,
  parameter int unsigned BLANK_TICKS   = 50,
  parameter int unsigned SCROLL_FRAMES = 20,
  parameter int unsigned MSG_LEN       = 32,
  parameter int unsigned AW            = 7
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ch0,
  input  logic                       ch1,
  input  logic                       en,
  output logic [AW-1:0]              rom_addr,
  input  logic [4:0]                 rom_data,
  output logic [6:0]                 col,
  output logic [4:0]                 lin,
  output logic                       frame_tick,
  output logic [$clog2(MSG_LEN)-1:0] offset
);

  localparam int unsigned OffW     = $clog2(MSG_LEN);
  localparam int unsigned MaxTicks = (COL_TICKS > BLANK_TICKS) ? COL_TICKS : BLANK_TICKS;
  localparam int unsigned TickW    = $clog2(MaxTicks) + 1;
  localparam int unsigned FrmW     = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
  localparam bit          HasBlank = (BLANK_TICKS != 0);

  localparam logic [TickW-1:0] ShowLast  = TickW'(COL_TICKS - 1);
  localparam logic [TickW-1:0] BlankLast = TickW'(HasBlank ? BLANK_TICKS - 1 : 0);
  localparam logic [FrmW-1:0]  FrameLast = FrmW'(SCROLL_FRAMES - 1);

  typedef enum logic [2:0] {StIdle, StFetch, StLoad, StShow, StBlank} state_e;

  state_e             state_q, state_d;
  logic [2:0]         col_idx_q, col_idx_d;
  logic [TickW-1:0]   tick_q, tick_d;
  logic [FrmW-1:0]    frame_q, frame_d;
  logic [OffW-1:0]    offset_q, offset_d;
  logic [1:0]         msg_q, msg_d;
  logic [1:0]         sync1_q, sw_s;
  logic [AW-1:0]      addr_q, addr_d;
  logic [6:0]         col_q, col_d;
  logic [4:0]         lin_q, lin_d;
  logic               col_end, frame_end;

  // Last cycle of a column: end of BLANK, or end of SHOW when there is no blank phase.
  assign col_end   = (state_q == StShow && tick_q == ShowLast && !HasBlank) ||
                     (state_q == StBlank && tick_q == BlankLast);
  assign frame_end = col_end && (col_idx_q == 3'd6);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      col_idx_q <= '0;
      tick_q    <= '0;
      frame_q   <= '0;
      offset_q  <= '0;
      msg_q     <= '0;
      sync1_q   <= '0;
      sw_s      <= '0;
      addr_q    <= '0;
      col_q     <= '0;
      lin_q     <= '0;
    end else begin
      state_q   <= state_d;
      col_idx_q <= col_idx_d;
      tick_q    <= tick_d;
      frame_q   <= frame_d;
      offset_q  <= offset_d;
      msg_q     <= msg_d;
      sync1_q   <= {ch1, ch0};
      sw_s      <= sync1_q;
      addr_q    <= addr_d;
      col_q     <= col_d;
      lin_q     <= lin_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    tick_d    = tick_q;
    unique case (state_q)
      StIdle: begin
        if (en) begin
          state_d   = StFetch;
          col_idx_d = '0;
        end
      end
      StFetch: state_d = StLoad;
      StLoad: begin
        state_d = StShow;
        tick_d  = '0;
      end
      StShow: begin
        if (tick_q == ShowLast) begin
          if (HasBlank) begin
            state_d = StBlank;
            tick_d  = '0;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      StBlank: begin
        if (tick_q != BlankLast) tick_d = tick_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (col_end) begin
      if (col_idx_q != 3'd6) begin
        col_idx_d = col_idx_q + 3'd1;
        state_d   = StFetch;
      end else begin
        col_idx_d = '0;
        state_d   = en ? StFetch : StIdle;
      end
    end
  end

  // Message select and scroll offset only move at the frame boundary; a new message wins
  // over a coincident scroll step so every message starts from its first column.
  always_comb begin
    msg_d    = msg_q;
    frame_d  = frame_q;
    offset_d = offset_q;
    if (frame_end) begin
      msg_d = sw_s;
      if (sw_s != msg_q) begin
        frame_d  = '0;
        offset_d = '0;
      end else if (frame_q == FrameLast) begin
        frame_d  = '0;
        offset_d = offset_q + 1'b1;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end
  end

  always_comb begin
    col_d  = '0;
    lin_d  = '0;
    addr_d = addr_q;
    if (state_d == StFetch) begin
      addr_d = AW'({msg_d, offset_d + OffW'(col_idx_d)});
    end
    if (state_d == StShow) begin
      col_d = 7'b1 << col_idx_d;
      lin_d = (state_q == StLoad) ? rom_data : lin_q;
    end
  end

  assign rom_addr   = addr_q;
  assign col        = col_q;
  assign lin        = lin_q;
  assign frame_tick = frame_end;
  assign offset     = offset_q;

endmodule

// File: doc/painel_scan_ctrl.md
Name: painel_scan_ctrl

Overview:
- Sequencer for the 5x7 LED panel.
- Scans the 7 columns one at a time with a blanking gap between columns, which prevents ghosting.
- Fetches each column's 5-bit row pattern from a synchronous message ROM.
- Advances a horizontal scroll offset every N frames.
- Selects one of 4 messages from the two panel switches, synchronised and applied only at frame boundaries.
- Replaces the free-running divider/counter/demux timing with one deterministic controller.

Parameters:
- COL_TICKS, 1000: clocks each column is lit (SHOW dwell); must be >= 1.
- BLANK_TICKS, 50: clocks all LEDs are off after each column; 0 means no blank phase.
- SCROLL_FRAMES, 20: full 7-column frames per scroll step; must be >= 1.
- MSG_LEN, 32: columns per message; must be a power of two and >= 8.
- AW, 7: ROM address width; equals 2 + log2(MSG_LEN).

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous active-low reset.
- ch0, in, 1: message select bit 0; asynchronous switch input.
- ch1, in, 1: message select bit 1; asynchronous switch input.
- en, in, 1: scan enable.
- rom_addr, out, AW: ROM address = {msg_sel[1:0], (offset + col_idx) mod MSG_LEN}.
- rom_data, in, 5: row pattern; valid one clock after rom_addr.
- col, out, 7: one-hot column drive, active-high; bit i drives Ci.
- lin, out, 5: row drive, active-high; bit j drives Lj.
- frame_tick, out, 1: one-clock pulse at the end of each frame.
- offset, out, log2(MSG_LEN): current scroll offset.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - col=0, lin=0, rom_addr=0, frame_tick=0, offset=0.
  - col_idx=0, frame counter=0, msg_sel=0, both synchroniser stages=0.
- Switch synchronisation:
  - {ch1,ch0} passes through a 2-flop synchroniser into sw_s.
  - sw_s is loaded into msg_sel only at a frame boundary, i.e. the cycle frame_tick is asserted.
  - If the loaded value differs from the old msg_sel, offset and the frame counter clear to 0 in that same cycle.
- FSM states: IDLE, FETCH, LOAD, SHOW, BLANK.
  - IDLE: col=0, lin=0. Goes to FETCH when en=1, with col_idx=0.
  - FETCH, 1 clock: rom_addr is driven for col_idx; col=0, lin=0.
  - LOAD, 1 clock: rom_data is captured into the row register at the end of the cycle; col=0, lin=0.
  - SHOW, COL_TICKS clocks: col = one-hot(col_idx), lin = row register.
  - BLANK, BLANK_TICKS clocks: col=0, lin=0. Skipped entirely when BLANK_TICKS=0.
- End of a column's last cycle (BLANK, or SHOW if BLANK_TICKS=0):
  - If col_idx < 6: col_idx+1, go to FETCH.
  - If col_idx == 6: frame end (see next item).
- Frame end:
  - frame_tick=1 for that cycle.
  - col_idx clears to 0 and the frame counter increments.
  - When the frame counter reaches SCROLL_FRAMES-1, it clears and offset increments, wrapping MSG_LEN-1 -> 0.
  - Next state is FETCH if en=1, else IDLE.
- Timing: column period = COL_TICKS + BLANK_TICKS + 2 clocks; frame period = 7 x column period.
- col and lin are registered outputs, updated on the state change. They are never both non-zero outside SHOW, and at most one col bit is ever high.
- en deasserted mid-frame: the current frame completes. Offset and msg_sel are preserved, and scanning resumes at column 0.
- Simultaneous message change and scroll step at the same boundary: the message change wins; offset=0 and the frame counter=0.
- Address arithmetic is log2(MSG_LEN)-bit addition with natural wrap. Example: offset=30, col_idx=5, MSG_LEN=32 gives column 3.
- Reset asserted mid-operation: all outputs go to 0 immediately (asynchronous). After release, the block waits in IDLE for en.

Test Plan:
1. Reset/idle: COL_TICKS=4, BLANK_TICKS=1, en=0 after reset.
   - Expect col=0, lin=0, frame_tick=0, offset=0 for 100 clocks.
2. Basic scan: en=1, ROM returns addr[4:0]+1.
   - Expect rom_addr=0 on the first FETCH.
   - Expect col=7'b0000001, lin=5'd1 for exactly 4 clocks, then 1 blank clock.
   - Expect 7 columns of 7 clocks each, and frame_tick every 49 clocks.
3. Scroll and wrap: SCROLL_FRAMES=2, MSG_LEN=32.
   - Expect offset to increment every 98 clocks.
   - After 31 steps, offset=31 and column 1 fetches address {msg,5'd0}.
   - On the next step, offset wraps to 0.
4. Message select: change {ch1,ch0}=2'b10 mid-frame.
   - Expect no rom_addr[6:5] change until after frame_tick.
   - Next frame uses rom_addr[6:5]=2'b10, with offset=0.
   - A glitch shorter than 2 clocks that returns before the boundary causes no change.
5. BLANK_TICKS=0 and en drop: set COL_TICKS=3 and deassert en in column 2.
   - Expect column period 5 with no all-off gap apart from FETCH/LOAD.
   - Frame completes, then IDLE with offset held.
6. Async reset in SHOW: assert rst_n=0 mid-column.
   - Expect col, lin and offset at 0 within the same cycle, with no clock edge needed.
